// File: rtl/mux9x1.sv
// 9:1 single-bit multiplexer with a registered copy of the output and invalid-select monitoring.
// Define MUX9X1_ERRCNT_EN to add the saturating err_cnt counter and its port.
module mux9x1 #(
    parameter int ERRCNT_W = 8
) (
    output logic                out,
    input  logic                i0,
    input  logic                i1,
    input  logic                i2,
    input  logic                i3,
    input  logic                i4,
    input  logic                i5,
    input  logic                i6,
    input  logic                i7,
    input  logic                i8,
    input  logic [3:0]          sel,
    input  logic                clk,
    input  logic                rst,
    output logic                out_q,
    output logic                sel_err,
    output logic                err_sticky
`ifdef MUX9X1_ERRCNT_EN
   ,output logic [ERRCNT_W-1:0] err_cnt
`endif
);

    logic sel_invalid;

    if (ERRCNT_W < 1) begin : g_width_check
        $error("mux9x1: ERRCNT_W must be at least 1");
    end

    // Every code is listed; an unknown select (X/Z) falls to the default and
    // is reported as invalid rather than picking an input.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned, which would infer a latch.
        out         = 1'b0;
        sel_invalid = 1'b0;
        case (sel)
            4'd0:  out = i0;
            4'd1:  out = i1;
            4'd2:  out = i2;
            4'd3:  out = i3;
            4'd4:  out = i4;
            4'd5:  out = i5;
            4'd6:  out = i6;
            4'd7:  out = i7;
            4'd8:  out = i8;
            4'd9:  sel_invalid = 1'b1;
            4'd10: sel_invalid = 1'b1;
            4'd11: sel_invalid = 1'b1;
            4'd12: sel_invalid = 1'b1;
            4'd13: sel_invalid = 1'b1;
            4'd14: sel_invalid = 1'b1;
            4'd15: sel_invalid = 1'b1;
            default: begin
                out         = 1'b0;
                sel_invalid = 1'b1;
            end
        endcase
    end

    // Reset wins over an invalid select in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            out_q      <= 1'b0;
            sel_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            out_q   <= out;
            sel_err <= sel_invalid;
            if (sel_invalid) begin
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef MUX9X1_ERRCNT_EN
    // Saturates at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (sel_invalid && (err_cnt != {ERRCNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mux9x1.sv
// Directed self-checking bench for mux9x1; err_cnt checks are included when
// MUX9X1_ERRCNT_EN is defined.
module tb_mux9x1;

    localparam int ERRCNT_W = 8;

    logic       clk;
    logic       rst;
    logic [8:0] d;      // d[k] drives ik
    logic [3:0] sel;
    logic       out;
    logic       out_q;
    logic       sel_err;
    logic       err_sticky;
`ifdef MUX9X1_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mux9x1 #(.ERRCNT_W(ERRCNT_W)) dut (
        .out        (out),
        .i0         (d[0]),
        .i1         (d[1]),
        .i2         (d[2]),
        .i3         (d[3]),
        .i4         (d[4]),
        .i5         (d[5]),
        .i6         (d[6]),
        .i7         (d[7]),
        .i8         (d[8]),
        .sel        (sel),
        .clk        (clk),
        .rst        (rst),
        .out_q      (out_q),
        .sel_err    (sel_err),
        .err_sticky (err_sticky)
`ifdef MUX9X1_ERRCNT_EN
       ,.err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int exp);
`ifdef MUX9X1_ERRCNT_EN
        check(tag, 32'(err_cnt), 32'(exp));
`endif
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive data/select mid-cycle and let the combinational path settle.
    task automatic drive(input logic [8:0] v, input logic [3:0] s);
        d   = v;
        sel = s;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        d   = '0;
        sel = 4'd0;
        tick();
        check("reset out_q", 32'(out_q), 0);
        check("reset sel_err", 32'(sel_err), 0);
        check("reset err_sticky", 32'(err_sticky), 0);
        check_cnt("reset err_cnt", 0);

        // out ignores rst
        drive(9'h1FF, 4'd3);
        check("out during rst", 32'(out), 1);
        tick();
        check("out_q held in rst", 32'(out_q), 0);
        rst = 1'b0;

        // all zero, sel 0
        drive(9'h000, 4'd0);
        check("zeros out", 32'(out), 0);
        tick();
        check("zeros out_q", 32'(out_q), 0);
        check("zeros sel_err", 32'(sel_err), 0);
        check("zeros err_sticky", 32'(err_sticky), 0);

        // all ones, sel 15
        drive(9'h1FF, 4'd15);
        check("sel15 out", 32'(out), 0);
        tick();
        check("sel15 sel_err", 32'(sel_err), 1);
        check("sel15 err_sticky", 32'(err_sticky), 1);
        check("sel15 out_q", 32'(out_q), 0);
        check_cnt("sel15 err_cnt", 1);

        // i0..i8 = 1,0,1,0,1,0,1,0,1 sel 12
        drive(9'b101010101, 4'd12);
        check("sel12 out", 32'(out), 0);
        tick();
        check("sel12 sel_err", 32'(sel_err), 1);
        // i0..i8 = 0,1,1,0,1,1,1,1,1 sel 3
        drive(9'b111110110, 4'd3);
        check("sel3 out", 32'(out), 0);
        check("sel3 sel_err before edge", 32'(sel_err), 1);
        tick();
        check("sel3 sel_err", 32'(sel_err), 0);
        check_cnt("after sel12 err_cnt", 2);

        // i0..i8 = 1,0,1,1,0,1,1,0,0 sel 2
        drive(9'b001101101, 4'd2);
        check("sel2 out", 32'(out), 1);
        tick();
        check("sel2 out_q", 32'(out_q), 1);
        // i0..i8 = 1,1,1,1,1,0,0,0,1 sel 5
        drive(9'b100011111, 4'd5);
        check("sel5 out", 32'(out), 0);
        check("sel5 out_q before edge", 32'(out_q), 1);
        tick();
        check("sel5 out_q", 32'(out_q), 0);
        check("sel5 err_sticky", 32'(err_sticky), 1);

        // one-hot walk over valid selects
        for (int s = 0; s < 9; s++) begin
            drive(9'(1 << s), 4'(s));
            check($sformatf("walk%0d hit out", s), 32'(out), 1);
            tick();
            check($sformatf("walk%0d out_q", s), 32'(out_q), 1);
            check($sformatf("walk%0d sel_err", s), 32'(sel_err), 0);
            drive(9'(1 << ((s + 1) % 9)), 4'(s));
            check($sformatf("walk%0d miss out", s), 32'(out), 0);
            check($sformatf("walk%0d out_q held", s), 32'(out_q), 1);
            tick();
            check($sformatf("walk%0d out_q low", s), 32'(out_q), 0);
        end

        // remaining invalid codes force 0 with all inputs high
        for (int s = 9; s < 15; s++) begin
            drive(9'h1FF, 4'(s));
            check($sformatf("invalid%0d out", s), 32'(out), 0);
            tick();
            check($sformatf("invalid%0d sel_err", s), 32'(sel_err), 1);
        end
        check_cnt("invalid sweep err_cnt", 8);

        // hold sel 9 long enough to saturate
        drive(9'h1FF, 4'd9);
        for (int n = 0; n < 300; n++) tick();
        check_cnt("saturated err_cnt", 255);
        check("long sel_err", 32'(sel_err), 1);
        check("long err_sticky", 32'(err_sticky), 1);
        tick();
        check_cnt("still saturated err_cnt", 255);

        // reset with invalid select present
        rst = 1'b1;
        tick();
        check("rst out_q", 32'(out_q), 0);
        check("rst sel_err", 32'(sel_err), 0);
        check("rst err_sticky", 32'(err_sticky), 0);
        check_cnt("rst err_cnt", 0);
        rst = 1'b0;
        drive(9'h000, 4'd0);
        tick();
        check("post-rst sel_err", 32'(sel_err), 0);
        check("post-rst err_sticky", 32'(err_sticky), 0);
        check_cnt("post-rst err_cnt", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
